bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 method (double dabble). One iteration per clock.
- Takes an unsigned binary value, for example a recognised digit count or a measured quantity.
- Produces six packed BCD digits for the 6-digit seven-segment display driver directly downstream.
- Holds the last result stable between conversions so the display never shows intermediate values.

---
 rtl/bin2bcd_seq.sv | 115 +++++++++++
 tb/tb_bin2bcd_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one iteration per clock.
// Optional macro BIN2BCD_SAT_EN: out-of-range values saturate bcd to 999999 instead of wrapping.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [23:0]      bcd
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StConv = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic [23:0]     bcd_q, bcd_d;
  logic [SR_W-1:0] adj;
  logic [SR_W-1:0] shifted;

  // Add-3 correction on every BCD nibble, then shift the whole register left.
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[SR_W-2:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          sr_d       = SR_W'(bin);
          cnt_d      = 5'd0;
          ovf_pend_d = 32'(bin) > 32'd999999;
          busy_d     = 1'b1;
          state_d    = StConv;
        end
      end
      StConv: begin
        sr_d  = shifted;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(BIN_W - 1)) begin
`ifdef BIN2BCD_SAT_EN
          if (ovf_pend_q) begin
            bcd_d = 24'h999999;
          end else begin
            bcd_d = shifted[SR_W-1 -: 24];
          end
`else
          // Bits shifted out of the top digit carry the 10^6 multiples, so the result wraps.
          bcd_d = shifted[SR_W-1 -: 24];
`endif
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      sr_q       <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= 24'h000000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed handshake cases plus random values vs. a decimal model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [23:0] bcd;

  int total = 0;
  int bad   = 0;

  bin2bcd_seq #(.BIN_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of v mod 10^6, computed arithmetically.
  task automatic model(input logic [19:0] v, output logic [23:0] eb, output logic eo);
    int unsigned m;
    int unsigned p;
    m  = int'(v) % 1000000;
    eo = int'(v) > 999999;
    p  = 1;
    for (int i = 0; i < 6; i++) begin
      eb[4*i +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
`ifdef BIN2BCD_SAT_EN
    if (eo) eb = 24'h999999;
`endif
  endtask

  // Issue start, wait (bounded) for done, check latency, busy span and result.
  // Returns in the done cycle so a caller may chain the next start back-to-back.
  task automatic run_conv(input logic [19:0] v, input string tag);
    logic [23:0] eb;
    logic        eo;
    int          k;
    int          busy_cnt;
    model(v, eb, eo);
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 20'($urandom);
    k        = 0;
    busy_cnt = 0;
    while (!done && k < 60) begin
      if (busy) busy_cnt++;
      tick();
      k++;
    end
    check({tag, "/latency"}, 32'(k), 32'd20);
    check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'd20);
    check({tag, "/bcd"}, 32'(bcd), 32'(eb));
    check({tag, "/ovf"}, 32'(ovf), 32'(eo));
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [23:0] eb;
    logic        eo;
    int          dones;
    logic [23:0] prev_bcd;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #23;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/ovf", 32'(ovf), 32'd0);
    check("reset/bcd", 32'(bcd), 32'h0);
    rst_n = 1'b1;
    tick();
    tick();

    run_conv(20'd123456, "t1");
    tick();
    check("t1/done_width", 32'(done), 32'd0);
    check("t1/bcd_hold", 32'(bcd), 32'h123456);

    // Back-to-back: second start issued in the done cycle of the first.
    run_conv(20'd0, "t2a");
    run_conv(20'd999999, "t2b");
    tick();
    check("t2/done_width", 32'(done), 32'd0);

    run_conv(20'd1048575, "t3");
    tick();

    // Start pulse during a conversion must be ignored.
    start = 1'b1;
    bin   = 20'd654321;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    bin   = 20'd111111;
    tick();
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      tick();
    end
    check("t4/done_count", 32'(dones), 32'd1);
    check("t4/bcd", 32'(bcd), 32'h654321);
    check("t4/busy_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-conversion.
    start = 1'b1;
    bin   = 20'd500000;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("t5/busy", 32'(busy), 32'd0);
    check("t5/done", 32'(done), 32'd0);
    check("t5/ovf", 32'(ovf), 32'd0);
    check("t5/bcd", 32'(bcd), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done) dones++;
    end
    check("t5/no_done", 32'(dones), 32'd0);
    run_conv(20'd42, "t5b");
    tick();

    // Random values, alternating idle gaps and back-to-back starts.
    for (int n = 0; n < 24; n++) begin
      logic [19:0] v;
      v = (n % 5 == 0) ? 20'($urandom_range(1000000, 1048575)) : 20'($urandom_range(0, 1048575));
      run_conv(v, $sformatf("rnd%0d", n));
      if (n % 2 == 1) begin
        prev_bcd = bcd;
        model(v, eb, eo);
        tick();
        check($sformatf("rnd%0d/hold", n), 32'(bcd), 32'(eb));
        check($sformatf("rnd%0d/hold_stable", n), 32'(bcd), 32'(prev_bcd));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
